// File: rtl/distribute_chain_scheduler_pkg.sv
// Shared defaults, FSM state type and rotated-priority helper for the
// distribution chain scheduler.
package distribute_chain_scheduler_pkg;

  localparam int unsigned DCS_DATA_WIDTH = 32;
  localparam int unsigned DCS_NUM_NODE   = 4;
  localparam int unsigned DCS_NUM_REQ    = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DELIVER = 1'b1
  } dcs_state_e;

  // Index reached by stepping 'off' places from 'base' around a ring of n.
  // Callers keep base < n and off <= n, so one conditional subtract wraps it.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/distribute_chain_scheduler_rr_arbiter_one_hot.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr_i, wrapping around NUM_REQ.
//   req_i   : per-requester request
//   ptr_i   : highest-priority index this cycle
//   en_i    : when low, no grant is issued
//   grant_o : one-hot grant (all zero when disabled or no request)
//   idx_o   : binary index of the granted requester
module distribute_chain_scheduler_rr_arbiter_one_hot
  import distribute_chain_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = DCS_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found_c;
  logic [IDX_W-1:0] cand_c;

  // Walk the ring starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_c = 1'b0;
    cand_c  = '0;
    if (en_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_c = IDX_W'(rot_idx(32'(ptr_i), k, NUM_REQ));
        if (!found_c && req_i[cand_c]) begin
          found_c         = 1'b1;
          grant_o[cand_c] = 1'b1;
          idx_o           = cand_c;
        end
      end
    end
  end

endmodule

// File: rtl/distribute_chain_scheduler.sv
// Shares one one-hot distribution chain among NUM_REQ requesters. A granted
// word is held and issued to every tap in its mask, possibly over several
// cycles as taps become ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req_valid  : per-requester valid
//   i_req_data   : requester r data at [r*DATA_WIDTH +: DATA_WIDTH]
//   i_req_mask   : requester r destination mask at [r*NUM_NODE +: NUM_NODE]
//   o_req_ready  : combinational one-hot grant
//   i_node_ready : per-tap readiness for a word on the next cycle
//   o_valid, o_en, o_cmd, o_data_bus : registered chain head
//   o_busy       : hold register occupied
module distribute_chain_scheduler
  import distribute_chain_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DCS_DATA_WIDTH,
  parameter int unsigned NUM_NODE   = DCS_NUM_NODE,
  parameter int unsigned NUM_REQ    = DCS_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
  input  logic [NUM_REQ*NUM_NODE-1:0]    i_req_mask,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_NODE-1:0]            i_node_ready,
  output logic                           o_valid,
  output logic [DATA_WIDTH-1:0]          o_data_bus,
  output logic                           o_en,
  output logic [NUM_NODE-1:0]            o_cmd,
  output logic                           o_busy
);

  localparam int unsigned REQ_IDX_W = $clog2(NUM_REQ);

  dcs_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [NUM_NODE-1:0]    hold_mask_q, hold_mask_d;
  logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                   valid_q, valid_d;
  logic [NUM_NODE-1:0]    cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic                   hold_valid_c;
  logic [NUM_NODE-1:0]    send_c;
  logic [NUM_NODE-1:0]    residual_c;
  logic                   can_load_c;
  logic [NUM_REQ-1:0]     grant_c;
  logic [REQ_IDX_W-1:0]   grant_idx_c;
  logic [DATA_WIDTH-1:0]  sel_data_c;
  logic [NUM_NODE-1:0]    sel_mask_c;

  assign hold_valid_c = (state_q == ST_DELIVER);
  assign send_c       = hold_valid_c ? (hold_mask_q & i_node_ready) : '0;
  assign residual_c   = hold_mask_q & ~send_c;
  // A new word may load in the same cycle the last residual taps drain.
  assign can_load_c   = !hold_valid_c || (residual_c == '0);

  distribute_chain_scheduler_rr_arbiter_one_hot #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (can_load_c),
    .grant_o (grant_c),
    .idx_o   (grant_idx_c)
  );

  assign o_req_ready = grant_c;

  // One-hot select of the granted requester's payload.
  always_comb begin
    sel_data_c = '0;
    sel_mask_c = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_c[r]) begin
        sel_data_c = sel_data_c | i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
        sel_mask_c = sel_mask_c | i_req_mask[r*NUM_NODE +: NUM_NODE];
      end
    end
  end

  // Next-state, hold register, pointer and chain-head outputs.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    rr_ptr_d    = rr_ptr_q;
    valid_d     = 1'b0;
    cmd_d       = '0;
    data_d      = data_q;

    if (send_c != '0) begin
      valid_d = 1'b1;
      cmd_d   = send_c;
      data_d  = hold_data_q;
    end

    if (grant_c != '0) begin
      rr_ptr_d = REQ_IDX_W'(rot_idx(32'(grant_idx_c), 1, NUM_REQ));
    end

    case (state_q)
      ST_IDLE: ;
      ST_DELIVER: begin
        hold_mask_d = residual_c;
        if (residual_c == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Zero-mask grants are consumed without occupying the hold register.
    if ((grant_c != '0) && (sel_mask_c != '0)) begin
      hold_data_d = sel_data_c;
      hold_mask_d = sel_mask_c;
      state_d     = ST_DELIVER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      rr_ptr_q    <= '0;
      valid_q     <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      rr_ptr_q    <= rr_ptr_d;
      valid_q     <= valid_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_en       = valid_q;
  assign o_cmd      = cmd_q;
  assign o_data_bus = data_q;
  assign o_busy     = hold_valid_c;

endmodule

// File: tb/tb_distribute_chain_scheduler.sv
// Directed bench for distribute_chain_scheduler with NUM_REQ=4, NUM_NODE=4,
// DATA_WIDTH=32. Inputs change 1 time unit after a rising edge; outputs are
// sampled there too, away from the active edge.
module tb_distribute_chain_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [15:0]  req_mask;
  logic [3:0]   req_ready;
  logic [3:0]   node_ready;
  logic         o_valid;
  logic [31:0]  o_data_bus;
  logic         o_en;
  logic [3:0]   o_cmd;
  logic         o_busy;

  int errors;
  int checks;

  distribute_chain_scheduler #(
    .DATA_WIDTH (32),
    .NUM_NODE   (4),
    .NUM_REQ    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_mask   (req_mask),
    .o_req_ready  (req_ready),
    .i_node_ready (node_ready),
    .o_valid      (o_valid),
    .o_data_bus   (o_data_bus),
    .o_en         (o_en),
    .o_cmd        (o_cmd),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] d, input logic [3:0] m);
    req_data[r*32 +: 32] = d;
    req_mask[r*4 +: 4]   = m;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_mask   = '0;
    node_ready = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 4'($urandom);
    req_data   = {$urandom, $urandom, $urandom, $urandom};
    req_mask   = 16'($urandom);
    node_ready = 4'($urandom);
    tick();
    tick();
    checks++;
    if ({o_valid, o_en, o_cmd, o_busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp %b", {o_valid, o_en, o_cmd, o_busy}, 7'b0);
    end
    checks++;
    if (o_data_bus !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp %h", o_data_bus, 32'h0);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({o_valid, o_en, o_cmd, o_busy, o_data_bus} !== 39'b0) begin
      errors++;
      $display("FAIL reset_release got %b/%h exp 0", {o_valid, o_en, o_cmd, o_busy}, o_data_bus);
    end
  endtask

  task automatic test_single_multicast();
    apply_reset();
    set_req(0, 32'h1111_1111, 4'b0101);
    node_ready = 4'b1111;
    req_valid  = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mc_grant got %b exp %b", req_ready, 4'b0001);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({o_valid, o_busy} !== 2'b01) begin
      errors++;
      $display("FAIL mc_loaded got %b exp %b", {o_valid, o_busy}, 2'b01);
    end
    tick();
    checks++;
    if ({o_valid, o_en, o_cmd} !== 6'b11_0101) begin
      errors++;
      $display("FAIL mc_issue got %b exp %b", {o_valid, o_en, o_cmd}, 6'b110101);
    end
    checks++;
    if (o_data_bus !== 32'h1111_1111) begin
      errors++;
      $display("FAIL mc_data got %h exp %h", o_data_bus, 32'h1111_1111);
    end
    tick();
    checks++;
    if ({o_valid, o_en, o_cmd, o_busy} !== 7'b0) begin
      errors++;
      $display("FAIL mc_after got %b exp %b", {o_valid, o_en, o_cmd, o_busy}, 7'b0);
    end
    checks++;
    if (o_data_bus !== 32'h1111_1111) begin
      errors++;
      $display("FAIL mc_data_hold got %h exp %h", o_data_bus, 32'h1111_1111);
    end
  endtask

  task automatic test_partial_delivery();
    apply_reset();
    set_req(1, 32'h2222_2222, 4'b1111);
    set_req(2, 32'h4444_4444, 4'b0001);
    req_valid  = 4'b0010;
    node_ready = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL pd_grant got %b exp %b", req_ready, 4'b0010);
    end
    tick();
    // Requester 2 waits behind the held word.
    req_valid = 4'b0100;
    #1;
    checks++;
    if ({req_ready, o_busy} !== 5'b0000_1) begin
      errors++;
      $display("FAIL pd_stall0 got %b exp %b", {req_ready, o_busy}, 5'b00001);
    end
    tick();
    checks++;
    if ({o_valid, o_cmd, o_data_bus} !== {1'b1, 4'b0011, 32'h2222_2222}) begin
      errors++;
      $display("FAIL pd_first got %b/%b/%h exp 1/0011/22222222", o_valid, o_cmd, o_data_bus);
    end
    node_ready = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({req_ready, o_busy} !== 5'b0000_1) begin
        errors++;
        $display("FAIL pd_stall%0d got %b exp %b", c + 1, {req_ready, o_busy}, 5'b00001);
      end
      tick();
      checks++;
      if ({o_valid, o_en, o_cmd} !== 6'b0) begin
        errors++;
        $display("FAIL pd_idle%0d got %b exp %b", c, {o_valid, o_en, o_cmd}, 6'b0);
      end
    end
    node_ready = 4'b1100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL pd_b2b_grant got %b exp %b", req_ready, 4'b0100);
    end
    tick();
    req_valid  = '0;
    node_ready = 4'b1111;
    checks++;
    if ({o_valid, o_cmd, o_busy, o_data_bus} !== {1'b1, 4'b1100, 1'b1, 32'h2222_2222}) begin
      errors++;
      $display("FAIL pd_second got %b/%b/%b/%h exp 1/1100/1/22222222", o_valid, o_cmd, o_busy, o_data_bus);
    end
    tick();
    checks++;
    if ({o_valid, o_cmd, o_busy, o_data_bus} !== {1'b1, 4'b0001, 1'b0, 32'h4444_4444}) begin
      errors++;
      $display("FAIL pd_next_word got %b/%b/%b/%h exp 1/0001/0/44444444", o_valid, o_cmd, o_busy, o_data_bus);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [31:0] exp_d;
    apply_reset();
    for (int r = 0; r < 4; r++) set_req(r, 32'(r), 4'b0001);
    node_ready = 4'b1111;
    req_valid  = 4'b1111;
    #1;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        exp_g = 4'b0001 << (k % 4);
        checks++;
        if (req_ready !== exp_g) begin
          errors++;
          $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_g);
        end
      end
      if (k >= 2) begin
        exp_d = 32'((k - 2) % 4);
        checks++;
        if ({o_valid, o_cmd, o_data_bus} !== {1'b1, 4'b0001, exp_d}) begin
          errors++;
          $display("FAIL rr_out%0d got %b/%b/%h exp 1/0001/%h", k, o_valid, o_cmd, o_data_bus, exp_d);
        end
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_zero_mask();
    apply_reset();
    set_req(2, 32'h3333_3333, 4'b0000);
    node_ready = 4'b1111;
    req_valid  = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL zm_grant got %b exp %b", req_ready, 4'b0100);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL zm_noload got %b exp %b", {o_valid, o_busy}, 2'b00);
    end
    set_req(0, 32'h0000_0005, 4'b0001);
    set_req(3, 32'h0000_0006, 4'b0010);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL zm_ptr got %b exp %b", req_ready, 4'b1000);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL zm_novalid got %b exp %b", o_valid, 1'b0);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if ({o_valid, o_cmd, o_data_bus} !== {1'b1, 4'b0010, 32'h0000_0006}) begin
      errors++;
      $display("FAIL zm_req3 got %b/%b/%h exp 1/0010/00000006", o_valid, o_cmd, o_data_bus);
    end
    tick();
  endtask

  task automatic test_reset_mid_delivery();
    apply_reset();
    set_req(1, 32'h7777_7777, 4'b1111);
    node_ready = 4'b0001;
    req_valid  = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rm_grant got %b exp %b", req_ready, 4'b0010);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if ({o_valid, o_cmd, o_busy} !== {1'b1, 4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL rm_first got %b exp %b", {o_valid, o_cmd, o_busy}, 6'b100011);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_en, o_cmd, o_busy, o_data_bus} !== 39'b0) begin
      errors++;
      $display("FAIL rm_async got %b/%h exp 0", {o_valid, o_en, o_cmd, o_busy}, o_data_bus);
    end
    tick();
    rst_n      = 1'b1;
    node_ready = 4'b1111;
    tick();
    tick();
    checks++;
    if ({o_valid, o_cmd, o_busy} !== 6'b0) begin
      errors++;
      $display("FAIL rm_noreissue got %b exp %b", {o_valid, o_cmd, o_busy}, 6'b0);
    end
    set_req(0, 32'h0000_00a0, 4'b0001);
    set_req(2, 32'h0000_00a2, 4'b0001);
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rm_ptr0 got %b exp %b", req_ready, 4'b0001);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_mask   = '0;
    node_ready = '0;
    test_reset();
    test_single_multicast();
    test_partial_delivery();
    test_round_robin();
    test_zero_mask();
    test_reset_mid_delivery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
